// File: rtl/wb_burst_master_if.sv
// Command, write-data, read-data and Wishbone signals for wb_burst_master.
// The master modport is the burst master's view; the slave modport is the view from the opposite side.
interface wb_burst_master_if #(
  parameter int unsigned LEN_W = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wdata_valid;
  logic             wdata_ready;
  logic [31:0]      wdata;
  logic             rdata_valid;
  logic             rdata_ready;
  logic [31:0]      rdata;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o;
  logic [31:0]      wbm_dat_o;
  logic [31:0]      wbm_dat_i;
  logic             wbm_ack_i;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
           wbm_dat_i, wbm_ack_i,
    output cmd_ready, wdata_ready, rdata_valid, rdata, wbm_cyc_o, wbm_stb_o, wbm_we_o,
           wbm_sel_o, wbm_adr_o, wbm_dat_o, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
           wbm_dat_i, wbm_ack_i,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, wbm_cyc_o, wbm_stb_o, wbm_we_o,
           wbm_sel_o, wbm_adr_o, wbm_dat_o, busy, done, err
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone classic burst initiator: one command becomes a run of single-beat word transfers,
// with a write-data stream, a read-data FIFO and a per-beat ack timeout.
module wb_burst_master #(
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_burst_master_if.master   bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StBus, StGap, StDone} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic             r_we;
  logic [31:0]      r_adr;
  logic [LEN_W-1:0] r_rem;
  logic [15:0]      r_tmo;
  logic [31:0]      r_dat_o;
  logic             r_cyc;
  logic             r_cmd_ready;
  logic             r_wdata_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_cnt;

  logic w_accept;
  logic w_take;
  logic w_ack;
  logic w_tmo_abort;
  logic w_room;
  logic w_push;
  logic w_pop;

  assign w_accept    = (r_state == StIdle) & bus.cmd_valid;
  assign w_take      = (r_state == StFetch) & bus.wdata_valid;
  assign w_ack       = (r_state == StBus) & bus.wbm_ack_i;
  // Ack in the last allowed cycle still completes the beat.
  assign w_tmo_abort = (r_state == StBus) & ~bus.wbm_ack_i & (r_tmo == TmoLast);
  assign w_room      = (r_cnt < FifoFull);
  assign w_push      = w_ack & ~r_we;
  assign w_pop       = (r_cnt != '0) & bus.rdata_ready;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0)  w_state_d = StDone;
          else if (bus.cmd_we)    w_state_d = StFetch;
          else if (w_room)        w_state_d = StBus;
          else                    w_state_d = StGap;  // latched read waiting for FIFO room
        end
      end
      StFetch: if (bus.wdata_valid) w_state_d = StBus;
      StBus: begin
        if (bus.wbm_ack_i)         w_state_d = StGap;
        else if (r_tmo == TmoLast) w_state_d = StDone;
      end
      StGap: begin
        if (r_rem == '0) w_state_d = StDone;
        else if (r_we)   w_state_d = StFetch;
        else if (w_room) w_state_d = StBus;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_we          <= 1'b0;
      r_adr         <= '0;
      r_rem         <= '0;
      r_tmo         <= '0;
      r_dat_o       <= '0;
      r_cyc         <= 1'b0;
      r_cmd_ready   <= 1'b1;
      r_wdata_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cmd_ready   <= (w_state_d == StIdle);
      r_wdata_ready <= (w_state_d == StFetch);
      r_cyc         <= (w_state_d == StBus);
      r_busy        <= (w_state_d != StIdle);
      r_done        <= (w_state_d == StDone);
      r_tmo         <= ((r_state == StBus) && (w_state_d == StBus)) ? r_tmo + 16'd1 : '0;
      if (w_accept) begin
        r_we  <= bus.cmd_we;
        r_adr <= {bus.cmd_addr[31:2], 2'b00};
        r_rem <= bus.cmd_len;
        r_err <= 1'b0;
      end
      if (w_take) r_dat_o <= bus.wdata;
      if (w_ack) begin
        r_rem <= r_rem - LEN_W'(1);
        r_adr <= r_adr + 32'd4;
      end
      if (w_tmo_abort) r_err <= 1'b1;
    end
  end

  // Read FIFO: room is checked before each read beat, so a push never meets a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.wbm_dat_i;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CntW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CntW'(1);
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.wdata_ready = r_wdata_ready;
  assign bus.rdata_valid = (r_cnt != '0);
  assign bus.rdata       = r_mem[r_rd_ptr];
  assign bus.wbm_cyc_o   = r_cyc;
  assign bus.wbm_stb_o   = r_cyc;
  assign bus.wbm_we_o    = r_we;
  assign bus.wbm_sel_o   = {4{r_cyc}};
  assign bus.wbm_adr_o   = r_adr;
  assign bus.wbm_dat_o   = r_dat_o;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: bus slave model, write-data feeder, negedge monitor
// and hand-computed expectations for write, read, backpressure, timeout, wrap and reset cases.
module tb_wb_burst_master;
  localparam int unsigned Tmo = 10;

  logic clk;
  logic rst_n;
  wb_burst_master_if #(.LEN_W(8)) bus ();

  wb_burst_master #(
    .LEN_W     (8),
    .FIFO_DEPTH(4),
    .TIMEOUT   (Tmo)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave model: ack when stb has been high for ack_dly earlier cycles; data = address low byte.
  logic ack_en;
  logic stray;
  int   ack_dly;
  int   stb_cnt = 0;
  always @(posedge clk) stb_cnt <= bus.wbm_cyc_o ? stb_cnt + 1 : 0;
  assign bus.wbm_ack_i = stray | (bus.wbm_cyc_o & ack_en & (stb_cnt == ack_dly));
  assign bus.wbm_dat_i = {24'h0, bus.wbm_adr_o[7:0]};

  // Write-data feeder walks a global word table up to wd_lim.
  logic [31:0] wd_tab [8];
  int wd_idx = 0;
  int wd_lim;
  always @(posedge clk) if (bus.wdata_valid && bus.wdata_ready) wd_idx <= wd_idx + 1;
  assign bus.wdata_valid = (wd_idx < wd_lim);
  assign bus.wdata       = wd_tab[wd_idx];

  // Monitor, sampled on the falling edge.
  logic [31:0] b_adr [64];
  logic [31:0] b_dat [64];
  logic        b_we  [64];
  int          gap_log [64];
  logic [31:0] rd_log [64];
  int nbeats = 0, nstarts = 0, nrd = 0, ndone = 0, prot_err = 0;
  int low_run = 0, hi_run = 0, last_hi = 0;
  logic prev_cyc = 1'b0;

  always @(negedge clk) begin
    if (bus.wbm_cyc_o) begin
      if (!prev_cyc && nstarts < 64) begin
        gap_log[nstarts] = low_run;
        nstarts++;
      end
      hi_run++;
      low_run = 0;
    end else begin
      if (prev_cyc) last_hi = hi_run;
      hi_run = 0;
      low_run++;
    end
    prev_cyc = bus.wbm_cyc_o;
    if (bus.wbm_cyc_o && bus.wbm_ack_i && nbeats < 64) begin
      b_adr[nbeats] = bus.wbm_adr_o;
      b_dat[nbeats] = bus.wbm_dat_o;
      b_we[nbeats]  = bus.wbm_we_o;
      nbeats++;
    end
    if (bus.done) ndone++;
    if (bus.rdata_valid && bus.rdata_ready && nrd < 64) begin
      rd_log[nrd] = bus.rdata;
      nrd++;
    end
    if ((bus.wbm_stb_o !== bus.wbm_cyc_o) ||
        (bus.wbm_cyc_o && bus.wbm_sel_o !== 4'hF) ||
        (!bus.wbm_cyc_o && bus.wbm_sel_o !== 4'h0)) prot_err++;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("cmd_ready_before_cmd", {31'h0, bus.cmd_ready}, 32'h1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic got_err, output int ncyc);
    logic seen = 1'b0;
    got_err = 1'b0;
    ncyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      ncyc++;
      if (bus.done) begin
        seen    = 1'b1;
        got_err = bus.err;
        break;
      end
    end
    check("done_seen", {31'h0, seen}, 32'h1);
    if (seen) begin
      @(negedge clk);
      check("done_one_cycle", {31'h0, bus.done}, 32'h0);
      check("idle_busy", {31'h0, bus.busy}, 32'h0);
      check("idle_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic e;
    int nc, b0, s0, r0, d0;

    wd_tab[0] = 32'h11; wd_tab[1] = 32'h22; wd_tab[2] = 32'h33; wd_tab[3] = 32'h44;
    wd_tab[4] = 32'hA5A5_0001; wd_tab[5] = 32'hA5A5_0002; wd_tab[6] = '0; wd_tab[7] = '0;
    wd_lim = 0;
    ack_en = 1'b1; ack_dly = 0; stray = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.rdata_ready = 1'b0;
    rst_n = 1'b0;

    // Reset values
    cycles(3);
    check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("rst_cyc", {31'h0, bus.wbm_cyc_o}, 32'h0);
    check("rst_sel", {28'h0, bus.wbm_sel_o}, 32'h0);
    check("rst_busy_done_err", {29'h0, bus.busy, bus.done, bus.err}, 32'h0);
    check("rst_rvalid_wready", {30'h0, bus.rdata_valid, bus.wdata_ready}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    cycles(2);

    // Write len=4, ack 2 cycles after stb
    ack_dly = 2; wd_lim = 4;
    b0 = nbeats; s0 = nstarts; d0 = ndone;
    send_cmd(1'b1, 32'h3000_0010, 8'd4);
    wait_done(200, e, nc);
    check("wr_err", {31'h0, e}, 32'h0);
    check("wr_nbeats", nbeats - b0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_adr%0d", i), b_adr[b0+i], 32'h3000_0010 + 32'(4 * i));
      check($sformatf("wr_dat%0d", i), b_dat[b0+i], 32'h11 * 32'(i + 1));
      check($sformatf("wr_we%0d", i), {31'h0, b_we[b0+i]}, 32'h1);
    end
    for (int i = 1; i < 4; i++) check($sformatf("wr_gap%0d", i), gap_log[s0+i], 2);
    check("wr_ndone", ndone - d0, 1);

    // Read len=6 with consumer stalled: only 4 beats until drained
    ack_dly = 1;
    b0 = nbeats; s0 = nstarts; r0 = nrd;
    send_cmd(1'b0, 32'h3000_0000, 8'd6);
    cycles(30);
    check("rd_stall_beats", nbeats - b0, 4);
    check("rd_stall_cyc", {31'h0, bus.wbm_cyc_o}, 32'h0);
    check("rd_stall_busy", {31'h0, bus.busy}, 32'h1);
    check("rd_stall_head", bus.rdata, 32'h0);
    bus.rdata_ready = 1'b1;
    wait_done(100, e, nc);
    cycles(4);
    check("rd_err", {31'h0, e}, 32'h0);
    check("rd_nbeats", nbeats - b0, 6);
    check("rd_ndrained", nrd - r0, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("rd_data%0d", i), rd_log[r0+i], 32'(4 * i));
    check("rd_gap1", gap_log[s0+1], 1);
    check("rd_gap5", gap_log[s0+5], 1);
    bus.rdata_ready = 1'b0;

    // Read len=2, slave never acks: timeout
    ack_en = 1'b0;
    b0 = nbeats;
    send_cmd(1'b0, 32'h3000_0100, 8'd2);
    wait_done(100, e, nc);
    check("tmo_err", {31'h0, e}, 32'h1);
    check("tmo_stb_cycles", last_hi, Tmo);
    check("tmo_no_beats", nbeats - b0, 0);
    check("tmo_no_push", {31'h0, bus.rdata_valid}, 32'h0);
    check("tmo_cyc", {31'h0, bus.wbm_cyc_o}, 32'h0);
    ack_en = 1'b1;

    // len=0 with a stray ack held high: no bus activity, done one cycle after accept
    stray = 1'b1;
    s0 = nstarts;
    send_cmd(1'b0, 32'h3000_0200, 8'd0);
    wait_done(20, e, nc);
    stray = 1'b0;
    check("len0_latency", nc, 1);
    check("len0_err", {31'h0, e}, 32'h0);
    check("len0_no_cyc", nstarts - s0, 0);
    check("len0_no_push", {31'h0, bus.rdata_valid}, 32'h0);

    // Address wrap, ack in the timeout cycle itself
    ack_dly = Tmo - 1; wd_lim = 6;
    b0 = nbeats;
    send_cmd(1'b1, 32'hFFFF_FFFC, 8'd2);
    wait_done(200, e, nc);
    check("wrap_err", {31'h0, e}, 32'h0);
    check("wrap_nbeats", nbeats - b0, 2);
    check("wrap_adr0", b_adr[b0], 32'hFFFF_FFFC);
    check("wrap_adr1", b_adr[b0+1], 32'h0000_0000);
    check("wrap_dat1", b_dat[b0+1], 32'hA5A5_0002);
    check("wrap_stb_cycles", last_hi, Tmo);

    // Reset during a read beat
    ack_dly = 3;
    b0 = nbeats;
    send_cmd(1'b0, 32'h3000_0200, 8'd8);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (nbeats >= b0 + 1 && bus.wbm_cyc_o) break;
    end
    check("rst_mid_in_beat", {31'h0, bus.wbm_cyc_o}, 32'h1);
    d0 = ndone;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_cyc_stb", {30'h0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'h0);
    check("rst_mid_done_busy", {30'h0, bus.done, bus.busy}, 32'h0);
    check("rst_mid_fifo", {31'h0, bus.rdata_valid}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    cycles(3);
    check("rst_mid_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("rst_mid_no_done", ndone - d0, 0);
    check("rst_mid_fifo_after", {31'h0, bus.rdata_valid}, 32'h0);

    ack_dly = 0; bus.rdata_ready = 1'b1;
    r0 = nrd;
    send_cmd(1'b0, 32'h3000_0040, 8'd2);
    wait_done(100, e, nc);
    cycles(3);
    check("post_rst_err", {31'h0, e}, 32'h0);
    check("post_rst_nrd", nrd - r0, 2);
    check("post_rst_d0", rd_log[r0], 32'h40);
    check("post_rst_d1", rd_log[r0+1], 32'h44);
    check("protocol", prot_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
